// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] SIGN_MASK_WORD = 3'b010;

    typedef enum logic {
        ST_CPU      = 1'b0,
        ST_AUX_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, auxiliary-master and memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cpu_memread;
    logic              cpu_memwrite;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_sign_mask;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              aux_req;
    logic              aux_we;
    logic              aux_lock;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_memwrite;
    logic              mem_memread;
    logic [2:0]        mem_sign_mask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata, cpu_sign_mask,
        output cpu_rdata, cpu_stall,
        input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_sign_mask,
        input  mem_rdata
    );

    modport master (
        output cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata, cpu_sign_mask,
        input  cpu_rdata, cpu_stall,
        output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_sign_mask,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter for the auxiliary master; hit_o flags the limit.
module starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int CNT_W = 3,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit_o = (cnt_q == LIMIT_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !hit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (default priority) and an
// auxiliary master that can lock the port and is protected from starvation.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    arb_state_e state_q;
    arb_state_e state_d;
    logic       cpu_req;
    logic       aux_win;
    logic       lock_idle;
    logic       starve_hit;
    logic       rvalid_q;
    logic       rvalid_d;

    assign cpu_req = bus.cpu_memread | bus.cpu_memwrite;

    starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .clr_i (aux_win),
        .inc_i (bus.aux_req & ~aux_win),
        .hit_o (starve_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CPU;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Lock is released after a cycle with aux_lock low; that cycle stays aux-owned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CPU:      if (aux_win && bus.aux_lock) state_d = ST_AUX_LOCK;
            ST_AUX_LOCK: if (!bus.aux_lock)           state_d = ST_CPU;
            default:     state_d = ST_CPU;
        endcase
    end

    always_comb begin
        aux_win   = 1'b0;
        lock_idle = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_AUX_LOCK: begin
                    aux_win   = bus.aux_req;
                    lock_idle = !bus.aux_req;
                end
                default: aux_win = bus.aux_req & (!cpu_req | starve_hit);
            endcase
        end

        rvalid_d       = aux_win & !bus.aux_we;
        bus.aux_gnt    = aux_win;
        bus.cpu_stall  = (aux_win | lock_idle) & cpu_req;
        bus.aux_rvalid = rvalid_q & !rst;
        bus.aux_rdata  = bus.mem_rdata;
        bus.cpu_rdata  = bus.mem_rdata;

        if (aux_win) begin
            bus.mem_addr      = bus.aux_addr;
            bus.mem_wdata     = bus.aux_wdata;
            bus.mem_sign_mask = SIGN_MASK_WORD;
            bus.mem_memwrite  = bus.aux_we;
            bus.mem_memread   = !bus.aux_we;
        end else begin
            bus.mem_addr      = bus.cpu_addr;
            bus.mem_wdata     = bus.cpu_wdata;
            bus.mem_sign_mask = bus.cpu_sign_mask;
            bus.mem_memwrite  = bus.cpu_memwrite & !rst & !lock_idle;
            bus.mem_memread   = bus.cpu_memread & !rst & !lock_idle;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected per-cycle port
// state and aux read data; a negedge monitor pops and compares.
module tb_dmem_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int OWN_CPU  = 0;
    localparam int OWN_AUX  = 1;
    localparam int OWN_IDLE = 2;

    typedef struct packed {
        logic              gnt;
        logic              stall;
        logic              mrd;
        logic              mwr;
        logic              rvalid;
        logic              chk_port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        mask;
        logic              chk_crd;
        logic [DATA_W-1:0] crd;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t              exp_q[$];
    string             name_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic              crd_pend;
    logic [DATA_W-1:0] crd_val;
    logic [DATA_W-1:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_memwrite) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_memread)  bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if ({bus.aux_gnt, bus.cpu_stall, bus.mem_memread, bus.mem_memwrite, bus.aux_rvalid}
                    !== {e.gnt, e.stall, e.mrd, e.mwr, e.rvalid}) begin
                bad++;
                $display("FAIL %s ctl gnt/stall/rd/wr/rvalid got=%b%b%b%b%b exp=%b%b%b%b%b", nm,
                         bus.aux_gnt, bus.cpu_stall, bus.mem_memread, bus.mem_memwrite, bus.aux_rvalid,
                         e.gnt, e.stall, e.mrd, e.mwr, e.rvalid);
            end
            if (e.chk_port) begin
                total++;
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_sign_mask} !== {e.addr, e.wdata, e.mask}) begin
                    bad++;
                    $display("FAIL %s port addr/wdata/mask got=%h/%h/%b exp=%h/%h/%b", nm,
                             bus.mem_addr, bus.mem_wdata, bus.mem_sign_mask, e.addr, e.wdata, e.mask);
                end
            end
            if (e.chk_crd) begin
                total++;
                if (bus.cpu_rdata !== e.crd) begin
                    bad++;
                    $display("FAIL %s cpu_rdata got=%h exp=%h", nm, bus.cpu_rdata, e.crd);
                end
            end
        end
        if (bus.aux_rvalid === 1'b1) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL aux_rdata unexpected rvalid got=%h exp=none", bus.aux_rdata);
            end else begin
                logic [DATA_W-1:0] d;
                d = rd_q.pop_front();
                if (bus.aux_rdata !== d) begin
                    bad++;
                    $display("FAIL aux_rdata got=%h exp=%h", bus.aux_rdata, d);
                end
            end
        end
    end

    task automatic set_cpu(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [2:0] m);
        bus.cpu_memread   = rd;
        bus.cpu_memwrite  = wr;
        bus.cpu_addr      = a;
        bus.cpu_wdata     = wd;
        bus.cpu_sign_mask = m;
    endtask

    task automatic set_aux(input logic req, input logic we, input logic lk,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bus.aux_req   = req;
        bus.aux_we    = we;
        bus.aux_lock  = lk;
        bus.aux_addr  = a;
        bus.aux_wdata = wd;
    endtask

    task automatic expect_crd(input logic [DATA_W-1:0] d);
        crd_pend = 1'b1;
        crd_val  = d;
    endtask

    // Owner is hand-chosen per vector; port contents follow from that owner's inputs.
    task automatic step(input string nm, input int own, input logic g, input logic st, input logic rv);
        exp_t e;
        e        = '0;
        e.gnt    = g;
        e.stall  = st;
        e.rvalid = rv;
        case (own)
            OWN_CPU: begin
                e.chk_port = 1'b1;
                e.mrd   = bus.cpu_memread;
                e.mwr   = bus.cpu_memwrite;
                e.addr  = bus.cpu_addr;
                e.wdata = bus.cpu_wdata;
                e.mask  = bus.cpu_sign_mask;
            end
            OWN_AUX: begin
                e.chk_port = 1'b1;
                e.mrd   = !bus.aux_we;
                e.mwr   = bus.aux_we;
                e.addr  = bus.aux_addr;
                e.wdata = bus.aux_wdata;
                e.mask  = 3'b010;
            end
            default: begin
                e.mrd = 1'b0;
                e.mwr = 1'b0;
            end
        endcase
        e.chk_crd = crd_pend;
        e.crd     = crd_val;
        crd_pend  = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        crd_pend = 1'b0;
        crd_val  = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 32'hDEADBEEF;
        rst = 1'b1;
        set_cpu(1'b0, 1'b0, '0, '0, 3'b010);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;

        // reset gates everything even with both masters requesting
        set_cpu(1'b1, 1'b0, 14'h0010, '0, 3'b010);
        set_aux(1'b1, 1'b0, 1'b1, 14'h0020, '0);
        step("rst_a", OWN_IDLE, 1'b0, 1'b0, 1'b0);
        step("rst_b", OWN_IDLE, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // CPU only
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        set_cpu(1'b0, 1'b1, 14'h0010, 32'h12345678, 3'b010);
        step("cpu_st", OWN_CPU, 1'b0, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b1, 14'h0011, 32'h000000AA, 3'b000);
        step("cpu_stb", OWN_CPU, 1'b0, 1'b0, 1'b0);
        set_cpu(1'b1, 1'b0, 14'h0010, '0, 3'b010);
        step("cpu_ld", OWN_CPU, 1'b0, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, 14'h0010, '0, 3'b010);
        expect_crd(32'h12345678);
        step("cpu_ld_data", OWN_CPU, 1'b0, 1'b0, 1'b0);

        // aux only, single and back-to-back reads
        set_aux(1'b1, 1'b0, 1'b0, 14'h0020, '0);
        rd_q.push_back(32'hDEADBEEF);
        step("aux_rd", OWN_AUX, 1'b1, 1'b0, 1'b0);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        step("aux_rd_v", OWN_CPU, 1'b0, 1'b0, 1'b1);
        set_aux(1'b1, 1'b0, 1'b0, 14'h0020, '0);
        rd_q.push_back(32'hDEADBEEF);
        step("aux_b2b_0", OWN_AUX, 1'b1, 1'b0, 1'b0);
        set_aux(1'b1, 1'b0, 1'b0, 14'h0010, '0);
        rd_q.push_back(32'h12345678);
        step("aux_b2b_1", OWN_AUX, 1'b1, 1'b0, 1'b1);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        step("aux_b2b_2", OWN_CPU, 1'b0, 1'b0, 1'b1);

        // contention: CPU wins four cycles, then aux is forced through
        set_cpu(1'b1, 1'b0, 14'h0030, '0, 3'b010);
        set_aux(1'b1, 1'b1, 1'b0, 14'h0040, 32'h00000055);
        for (int i = 0; i < 4; i++) step("starve_cpu", OWN_CPU, 1'b0, 1'b0, 1'b0);
        step("starve_aux", OWN_AUX, 1'b1, 1'b1, 1'b0);
        step("starve_back", OWN_CPU, 1'b0, 1'b0, 1'b0);
        step("starve_back2", OWN_CPU, 1'b0, 1'b0, 1'b0);
        // count (now 2) must hold while aux is quiet
        set_aux(1'b0, 1'b1, 1'b0, 14'h0040, 32'h00000055);
        step("hold_idle", OWN_CPU, 1'b0, 1'b0, 1'b0);
        set_aux(1'b1, 1'b1, 1'b0, 14'h0040, 32'h00000055);
        step("hold_c2", OWN_CPU, 1'b0, 1'b0, 1'b0);
        step("hold_c3", OWN_CPU, 1'b0, 1'b0, 1'b0);
        step("hold_aux", OWN_AUX, 1'b1, 1'b1, 1'b0);

        // locked burst of three writes with gaps
        set_cpu(1'b0, 1'b0, 14'h0050, 32'h00000077, 3'b010);
        set_aux(1'b1, 1'b1, 1'b1, 14'h0060, 32'h00000011);
        step("lk_start", OWN_AUX, 1'b1, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b1, 14'h0050, 32'h00000077, 3'b010);
        set_aux(1'b0, 1'b0, 1'b1, '0, '0);
        step("lk_gap0", OWN_IDLE, 1'b0, 1'b1, 1'b0);
        set_aux(1'b1, 1'b1, 1'b1, 14'h0061, 32'h00000022);
        step("lk_w1", OWN_AUX, 1'b1, 1'b1, 1'b0);
        set_aux(1'b0, 1'b0, 1'b1, '0, '0);
        set_cpu(1'b0, 1'b0, 14'h0050, 32'h00000077, 3'b010);
        step("lk_gap1", OWN_IDLE, 1'b0, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b1, 14'h0050, 32'h00000077, 3'b010);
        step("lk_gap2", OWN_IDLE, 1'b0, 1'b1, 1'b0);
        set_aux(1'b1, 1'b1, 1'b0, 14'h0062, 32'h00000033);
        step("lk_last", OWN_AUX, 1'b1, 1'b1, 1'b0);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        step("lk_resume", OWN_CPU, 1'b0, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, '0, '0, 3'b010);
        set_aux(1'b1, 1'b0, 1'b0, 14'h0061, '0);
        rd_q.push_back(32'h00000022);
        step("lk_chk", OWN_AUX, 1'b1, 1'b0, 1'b0);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        step("lk_chk_v", OWN_CPU, 1'b0, 1'b0, 1'b1);

        // reset in the rvalid cycle cancels the pending read
        set_aux(1'b1, 1'b0, 1'b0, 14'h0020, '0);
        step("rr_gnt", OWN_AUX, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b0, 14'h0010, '0, 3'b010);
        step("rr_rst", OWN_IDLE, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("rr_cpu", OWN_CPU, 1'b0, 1'b0, 1'b0);

        // reset mid-lock drops the lock
        set_cpu(1'b0, 1'b0, '0, '0, 3'b010);
        set_aux(1'b1, 1'b1, 1'b1, 14'h0070, 32'h00000044);
        step("rl_gnt", OWN_AUX, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        set_aux(1'b0, 1'b0, 1'b1, '0, '0);
        set_cpu(1'b0, 1'b1, 14'h0071, 32'h00000005, 3'b010);
        step("rl_rst", OWN_IDLE, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("rl_cpu", OWN_CPU, 1'b0, 1'b0, 1'b0);

        set_cpu(1'b0, 1'b0, '0, '0, 3'b010);
        set_aux(1'b0, 1'b0, 1'b0, '0, '0);
        step("end", OWN_CPU, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        total++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending exp=%0d rd=%0d required=0/0", exp_q.size(), rd_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU pipeline's MEM-side access (port 0) and an auxiliary bus master (port 1), such as the program loader or debug unit. The block sits between the CPU's data-memory outputs and the data memory.
- CPU has default priority.
- The auxiliary master is guaranteed service by a starvation counter and may lock the memory for multi-beat transfers.
- When the CPU loses arbitration, the block stalls it with `cpu_stall`.

## Interface
Parameters:
- ADDR_W, 14, data-memory address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive aux wait cycles before aux is forced ahead of the CPU (≥1)
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_memread  in  1  CPU load request
- cpu_memwrite  in  1  CPU store request
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_sign_mask  in  3  CPU size/sign mask
- cpu_rdata  out  DATA_W  load data, equal to mem_rdata
- cpu_stall  out  1  CPU must hold its request and freeze the pipeline
- aux_req  in  1  aux access request
- aux_we  in  1  aux write (1) or read (0)
- aux_lock  in  1  aux requests exclusive ownership over following cycles
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux store data
- aux_gnt  out  1  aux access accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  DATA_W  aux read data
- mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_sign_mask  out  ADDR_W/DATA_W/1/1/3  memory port
- mem_rdata  in  DATA_W  memory read data; 1-cycle latency after mem_memread

## Operation
- cpu_req = cpu_memread | cpu_memwrite.
- State machine, registered:
  - ST_CPU is the reset state.
  - ST_AUX_LOCK.
- Grant decision is combinational each cycle.
  - ST_AUX_LOCK: aux wins if aux_req.
  - ST_CPU: aux wins if aux_req & (!cpu_req | starve_cnt == STARVE_LIMIT). Otherwise the CPU wins if cpu_req.
- Aux win:
  - aux_gnt = 1.
  - The memory port is driven from aux_* with mem_sign_mask = SIGN_MASK_WORD.
  - mem_memwrite = aux_we and mem_memread = !aux_we.
  - cpu_stall = cpu_req.
- CPU win or idle:
  - The memory port is driven from cpu_*.
  - aux_gnt = 0 and cpu_stall = 0.
- ST_AUX_LOCK with !aux_req:
  - The memory is idle: mem_memread = mem_memwrite = 0.
  - cpu_stall = cpu_req, so the lock holds even between aux beats.
- Transitions:
  - ST_CPU → ST_AUX_LOCK when aux_gnt & aux_lock.
  - ST_AUX_LOCK → ST_CPU at the end of any cycle with aux_lock = 0. That cycle is still aux-owned.
- starve_cnt:
  - Clears on aux_gnt.
  - Otherwise increments when aux_req & !aux_gnt, saturating at STARVE_LIMIT.
  - Holds when aux_req = 0.
- aux_rvalid is a register, set to aux_gnt & !aux_we.
- aux_rdata = mem_rdata, and is meaningful only when aux_rvalid = 1.
- cpu_rdata = mem_rdata unconditionally.

## Timing
- Grant, stall and port muxing have 0-cycle latency, because the CPU presents its address in EX.
- Aux read data arrives 1 cycle after aux_gnt. Aux write completes in the grant cycle.
- Back-to-back aux reads: rvalid is asserted in consecutive cycles.
- A stalled CPU access is re-arbitrated every cycle. The CPU is served in the first cycle it wins; no buffering.
- Simultaneous cpu_req & aux_req with starve_cnt < STARVE_LIMIT: the CPU wins and the count increments.
- Worst-case aux wait in ST_CPU is STARVE_LIMIT cycles. After one forced grant the counter clears, and the CPU wins next if requesting.
- While rst = 1, and in the cycle after:
  - state = ST_CPU, starve_cnt = 0, aux_rvalid = 0.
  - Reset gates aux_gnt = 0, cpu_stall = 0, mem_memread = mem_memwrite = 0 while rst = 1.
- Reset mid-lock or mid-read drops the lock and any pending rvalid. The aux master must reissue.

## Structure
- Shared package/defines file holds:
  - SIGN_MASK_WORD (3'b010)
  - state encodings ST_CPU = 1'b0 and ST_AUX_LOCK = 1'b1
  - default widths ADDR_W/DATA_W
- One natural sub-module, `starve_counter`: saturating counter with clear, increment and limit-hit output.
- The port mux is inline.

## Test plan
- CPU-only loads and stores (aux_req = 0):
  - the memory port mirrors cpu_*, cpu_stall = 0 throughout;
  - a load from 0x0010 returns mem_rdata on cpu_rdata the next cycle.
- Aux-only read of 0x0020 with memory returning 0xDEADBEEF:
  - aux_gnt = 1 in cycle N;
  - aux_rvalid = 1 and aux_rdata = 0xDEADBEEF in N+1.
- Continuous cpu_req and aux_req, STARVE_LIMIT = 4:
  - the CPU wins 4 cycles;
  - cycle 5 gives aux_gnt = 1 and cpu_stall = 1;
  - cycle 6 goes back to the CPU with the counter at 0.
- aux_lock burst of 3 writes with gaps:
  - cpu_stall = cpu_req for the entire lock, including idle gaps;
  - the CPU resumes the cycle after aux_lock falls.
- Aux read granted, then rst asserted in the rvalid cycle:
  - aux_rvalid = 0, state = ST_CPU;
  - the next cpu_req is served immediately with cpu_stall = 0.
